// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the sigmoid lookup-table loader and its consumers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sigmoid_pkg;

    // Table geometry: one entry per 8-bit segment of z_value.
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TABLE_DEPTH = 2 ** ADDR_W;

    // Entry format is signed Q8.24: INT_W integer bits (sign included), FRAC_W fraction bits.
    localparam int FRAC_W = 24;
    localparam int INT_W  = 8;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/sigmoid_table_mem.sv
// Sigmoid table storage: one write port, two independent read ports with registered outputs.
// Latency: writes land on the clock edge; read data appears one cycle after rd_en.
// Backpressure: none; every enabled read and write completes, read outputs hold when rd_en is low.
module sigmoid_table_mem
    import sigmoid_pkg::TABLE_DEPTH;
#(
    parameter int ADDR_W = sigmoid_pkg::ADDR_W,
    parameter int DATA_W = sigmoid_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage carries no reset so it can later be swapped for a RAM macro.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: entries are stored bit-exact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read ports: capture both samples on an accepted request, otherwise hold the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= mem_q[rd_addr_a];
            rd_data_b <= mem_q[rd_addr_b];
        end
    end

    // The package depth and this instance's depth must agree for the default build.
    logic unused_depth;
    assign unused_depth = (TABLE_DEPTH == DEPTH);

endmodule

// File: rtl/sigmoid_table_loader.sv
// Run-time loadable sigmoid table: streams 256 Q8.24 entries in, serves base/next-segment lookups.
// Latency: in_ready one cycle after load_start; lookup result exactly one cycle after an accepted rd_en.
// Backpressure: in_ready is high only while loading (1 entry/cycle); lookups are dropped while busy or table invalid.
module sigmoid_table_loader
    import sigmoid_pkg::load_state_t;
    import sigmoid_pkg::ST_IDLE;
    import sigmoid_pkg::ST_LOAD;
    import sigmoid_pkg::ST_DONE;
#(
    parameter int ADDR_W = sigmoid_pkg::ADDR_W,
    parameter int DATA_W = sigmoid_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              load_done,
    output logic              table_ok,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    load_state_t       state_q;
    load_state_t       state_d;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic              table_ok_q;
    logic              rd_valid_q;
    logic              wr_fire;
    logic              busy_next;
    logic              rd_accept;
    logic [ADDR_W-1:0] next_addr;

    // A beat is written only while loading; a load_start in the same cycle restarts and discards it.
    assign wr_fire = (state_q == ST_LOAD) && in_valid && !load_start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore-style handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (in_valid && (wr_cnt_q == ADDR_MAX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The table is not valid until this cycle completes, so keep reporting busy.
                busy      = 1'b1;
                load_done = 1'b1;
                state_d   = load_start ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write pointer and table-valid flag; a new load invalidates the table immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            table_ok_q <= 1'b0;
        end else if (load_start) begin
            wr_cnt_q   <= '0;
            table_ok_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + ADDR_ONE;
            end
            if (state_q == ST_DONE) begin
                table_ok_q <= 1'b1;
            end
        end
    end

    // Lookups use the next-cycle busy so a read racing a load_start never sees a half-written table.
    assign busy_next = (state_d != ST_IDLE);
    assign rd_accept = rd_en && table_ok_q && !busy_next;

    // Next-segment address saturates at the top entry, flattening the curve beyond the table.
    assign next_addr = (rd_addr == ADDR_MAX) ? rd_addr : (rd_addr + ADDR_ONE);

    // Result-valid flag tracks the registered read one cycle behind the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    sigmoid_table_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_fire),
        .wr_addr   (wr_cnt_q),
        .wr_data   (in_data),
        .rd_en     (rd_accept),
        .rd_addr_a (rd_addr),
        .rd_addr_b (next_addr),
        .rd_data_a (base),
        .rd_data_b (next_data)
    );

    assign table_ok = table_ok_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sigmoid_table_loader.sv
// Self-checking bench for sigmoid_table_loader: scripted loads, a bench-side table model and a lookup scoreboard.
// Latency: expects in_ready one cycle after load_start and lookup results one cycle after rd_en.
// Backpressure: drives in_valid continuously or throttled; lookups during loads must be dropped.
module tb_sigmoid_table_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        load_done;
    logic        table_ok;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] base;
    logic [31:0] next_data;

    int          n_cmp;
    int          n_err;
    logic [31:0] model [256];
    logic [31:0] stage [256];
    bit          model_ok;
    logic [31:0] last_base;
    logic [31:0] last_next;
    logic [63:0] sb [$];

    sigmoid_table_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .load_done  (load_done),
        .table_ok   (table_ok),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .base       (base),
        .next_data  (next_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Issue consecutive lookups; accepted ones are scoreboarded and compared one cycle later.
    task automatic read_burst(input int start, input int count);
        logic [63:0] exp_pair;
        logic        acc;
        logic [7:0]  a;
        logic [7:0]  an;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            a       = 8'(start + k);
            an      = (a == 8'hFF) ? 8'hFF : a + 8'd1;
            rd_en   = 1'b1;
            rd_addr = a;
            acc     = model_ok;
            if (acc) sb.push_back({model[a], model[an]});
            @(posedge clk);
            #1;
            n_cmp++;
            if (rd_valid !== acc) begin
                n_err++;
                $display("FAIL rd_valid addr=%0d: got %b want %b", a, rd_valid, acc);
            end
            if (acc) begin
                exp_pair = sb.pop_front();
                n_cmp++;
                if ({base, next_data} !== exp_pair) begin
                    n_err++;
                    $display("FAIL lookup addr=%0d: got base=%h next=%h want base=%h next=%h",
                             a, base, next_data, exp_pair[63:32], exp_pair[31:0]);
                end
                last_base = exp_pair[63:32];
                last_next = exp_pair[31:0];
            end else begin
                n_cmp++;
                if ({base, next_data} !== {last_base, last_next}) begin
                    n_err++;
                    $display("FAIL hold addr=%0d: got base=%h next=%h want base=%h next=%h",
                             a, base, next_data, last_base, last_next);
                end
            end
        end
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Stream stage[0..n_beats-1]; a garbage beat rides on the load_start cycle and must be discarded.
    task automatic load_table(input int n_beats, input bit throttle, input bit rd_with_start, input int rd_beat);
        int i;
        bit gap;
        bit rd_chk;
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'hBAD0_BAD0;
        rd_en      = rd_with_start;
        rd_addr    = 8'd7;
        model_ok   = 1'b0;
        @(posedge clk);
        #1;
        if (rd_with_start) begin
            n_cmp++;
            if (rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL start_collision rd_valid: got %b want 0", rd_valid);
            end
        end
        n_cmp++;
        if ({in_ready, busy, table_ok} !== 3'b110) begin
            n_err++;
            $display("FAIL load_entry {in_ready,busy,table_ok}: got %b want 110", {in_ready, busy, table_ok});
        end
        i   = 0;
        gap = 1'b0;
        while (i < n_beats) begin
            @(negedge clk);
            load_start = 1'b0;
            rd_en      = 1'b0;
            if (throttle && gap) begin
                in_valid = 1'b0;
                in_data  = ~stage[i];
                gap      = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stage[i];
                gap      = throttle;
            end
            rd_chk = (i == rd_beat) && in_valid;
            if (rd_chk) begin
                rd_en   = 1'b1;
                rd_addr = 8'(i);
            end
            @(posedge clk);
            #1;
            if (in_valid) i++;
            n_cmp++;
            if (load_done !== 1'(i == 256) || in_ready !== 1'(i < 256)) begin
                n_err++;
                $display("FAIL load_beat %0d {load_done,in_ready}: got %b%b want %b%b",
                         i, load_done, in_ready, 1'(i == 256), 1'(i < 256));
            end
            if (rd_chk) begin
                n_cmp++;
                if (rd_valid !== 1'b0 || base !== last_base) begin
                    n_err++;
                    $display("FAIL read_during_load: got valid=%b base=%h want valid=0 base=%h",
                             rd_valid, base, last_base);
                end
            end
        end
        @(negedge clk);
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        load_start = 1'b0;
        if (n_beats == 256) begin
            n_cmp++;
            if (table_ok !== 1'b0) begin
                n_err++;
                $display("FAIL table_ok_in_done: got %b want 0", table_ok);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({load_done, table_ok, busy, in_ready} !== 4'b0100) begin
                n_err++;
                $display("FAIL after_done {load_done,table_ok,busy,in_ready}: got %b want 0100",
                         {load_done, table_ok, busy, in_ready});
            end
            model    = stage;
            model_ok = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({in_ready, busy, load_done, table_ok, rd_valid} !== 5'b0 || base !== 32'h0 || next_data !== 32'h0) begin
            n_err++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b ok=%b vld=%b base=%h next=%h want all zero",
                     tag, in_ready, busy, load_done, table_ok, rd_valid, base, next_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
        model_ok = 1'b0; last_base = '0; last_next = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        read_burst(3, 2);
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 256; i++) stage[i] = 32'(i) << 24;
        load_table(256, 1'b0, 1'b0, -1);
        read_burst(5, 1);
        read_burst(0, 1);
    endtask

    task automatic test_top_saturation();
        read_burst(255, 1);
        read_burst(254, 1);
    endtask

    task automatic test_pipelined();
        read_burst(0, 4);
    endtask

    task automatic test_idle_ignore();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({in_ready, load_done, table_ok} !== 3'b001) begin
                n_err++;
                $display("FAIL idle_ignore {in_ready,load_done,table_ok}: got %b want 001",
                         {in_ready, load_done, table_ok});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        read_burst(0, 4);
        read_burst(252, 4);
    endtask

    task automatic test_throttled();
        for (int i = 0; i < 256; i++) stage[i] = $urandom;
        load_table(256, 1'b1, 1'b0, -1);
        read_burst(0, 256);
    endtask

    task automatic test_restart();
        for (int i = 0; i < 256; i++) stage[i] = 32'h1234_0000 | 32'(i);
        load_table(100, 1'b0, 1'b1, -1);
        for (int i = 0; i < 256; i++) stage[i] = 32'h0080_0000;
        load_table(256, 1'b0, 1'b0, 40);
        read_burst(0, 8);
        read_burst(96, 8);
        read_burst(248, 8);
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 256; i++) stage[i] = ~(32'(i) << 16);
        load_table(50, 1'b0, 1'b0, -1);
        #2;
        rst_n     = 1'b0;
        model_ok  = 1'b0;
        last_base = '0;
        last_next = '0;
        #1;
        check_reset_outputs("reset_midload");
        @(negedge clk);
        rst_n = 1'b1;
        read_burst(5, 2);
    endtask

    task automatic test_recover();
        for (int i = 0; i < 256; i++) stage[i] = 32'(i) * 32'h0101_0101;
        load_table(256, 1'b0, 1'b0, -1);
        read_burst(250, 6);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_full_load();
        test_top_saturation();
        test_pipelined();
        test_idle_ignore();
        test_throttled();
        test_restart();
        test_reset_midload();
        test_recover();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
